bitstream_stuff: RTL and testbench

BITSTREAM_STUFF -- requirements
Module: bitstream_stuff

---
 rtl/bitstream_stuff_pkg.sv | 31 +++
 rtl/bitstream_stuff_if.sv | 26 ++
 rtl/bitstream_stuff_byte_stuffer.sv | 133 +++++++++++++
 rtl/bitstream_stuff.sv | 85 ++++++++
 tb/tb_bitstream_stuff.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bitstream_stuff_pkg.sv
// Shared widths, marker/stuff constants and byte-stage state encoding for the
// bitstream packer and its byte stuffer.
package bitstream_stuff_pkg;

  localparam int CODE_W = 32;
  localparam int LEN_W  = 6;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] MARKER_BYTE = 8'hFF;
  localparam logic [BYTE_W-1:0] STUFF_BYTE  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_STUFF = 2'd2
  } stuff_state_e;

  // Byte 0 is the oldest (most significant) byte of a word.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [CODE_W-1:0] w,
                                                 input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bitstream_stuff_if.sv
// Code input / byte output bundle of the bitstream packer.
// Handshake: a code is taken on every rising edge where ilength != 0 (no ready);
// valid marks jpeg as a real output byte in that cycle (no backpressure).
interface bitstream_stuff_if;
  import bitstream_stuff_pkg::*;

  logic [LEN_W-1:0]  ilength;
  logic [CODE_W-1:0] idata;
  logic [CODE_W-1:0] inostuff;
  logic [2:0]        rest;
  logic              valid;
  logic [BYTE_W-1:0] jpeg;
  logic              overflow;
  stuff_state_e      dbg_state;

  modport master (
    output ilength, idata, inostuff,
    input  rest, valid, jpeg, overflow, dbg_state
  );

  modport slave (
    input  ilength, idata, inostuff,
    output rest, valid, jpeg, overflow, dbg_state
  );

endinterface

// File: rtl/bitstream_stuff_byte_stuffer.sv
// Word FIFO plus word-to-byte serialiser that inserts 0x00 after every 0xFF
// data byte not covered by the stuffing-exempt mask.
module bitstream_stuff_byte_stuffer
  import bitstream_stuff_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [CODE_W-1:0] i_wr_data,
  input  logic [CODE_W-1:0] i_wr_mask,
  output logic              o_valid,
  output logic [BYTE_W-1:0] o_jpeg,
  output logic              o_overflow,
  output stuff_state_e      o_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CODE_W-1:0] r_mem_d [FIFO_DEPTH];
  logic [CODE_W-1:0] r_mem_m [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [CODE_W-1:0] r_word_d, r_word_m;
  logic [2:0]        r_idx;
  stuff_state_e      r_state;
  logic              r_valid;
  logic [BYTE_W-1:0] r_jpeg;
  logic              r_overflow;

  logic [AW:0]       w_count;
  logic              w_empty, w_full, w_pop, w_wr_ok, w_drop;
  logic [CODE_W-1:0] w_head_d, w_head_m, w_src_d, w_src_m;
  logic [1:0]        w_src_idx;
  logic              w_emit;
  logic [BYTE_W-1:0] w_byte, w_bmask, w_out_byte;
  logic              w_out_valid;
  logic [2:0]        w_nxt_idx;
  stuff_state_e      w_nxt_state;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_head_d = r_mem_d[r_rd_ptr[AW-1:0]];
  assign w_head_m = r_mem_m[r_rd_ptr[AW-1:0]];
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign w_wr_ok  = i_wr && (!w_full || w_pop);
  assign w_drop   = i_wr && w_full && !w_pop;

  always_comb begin
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_src_d     = r_word_d;
    w_src_m     = r_word_m;
    w_src_idx   = r_idx[1:0];
    w_out_valid = 1'b0;
    w_out_byte  = '0;
    w_nxt_idx   = r_idx;
    w_nxt_state = r_state;
    w_byte      = '0;
    w_bmask     = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_emit    = 1'b1;
          w_src_d   = w_head_d;
          w_src_m   = w_head_m;
          w_src_idx = 2'd0;
        end
      end
      ST_EMIT: w_emit = 1'b1;
      ST_STUFF: begin
        w_out_valid = 1'b1;
        w_out_byte  = STUFF_BYTE;
        w_nxt_state = (r_idx == 3'd4) ? ST_IDLE : ST_EMIT;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    if (w_emit) begin
      w_byte      = get_byte(w_src_d, w_src_idx);
      w_bmask     = get_byte(w_src_m, w_src_idx);
      w_out_valid = 1'b1;
      w_out_byte  = w_byte;
      w_nxt_idx   = {1'b0, w_src_idx} + 3'd1;
      if (w_byte == MARKER_BYTE && w_bmask != MARKER_BYTE)
        w_nxt_state = ST_STUFF;
      else if (w_nxt_idx == 3'd4)
        w_nxt_state = ST_IDLE;
      else
        w_nxt_state = ST_EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem_d[r_wr_ptr[AW-1:0]] <= i_wr_data;
      r_mem_m[r_wr_ptr[AW-1:0]] <= i_wr_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_word_d   <= '0;
      r_word_m   <= '0;
      r_idx      <= '0;
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_jpeg     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_word_d <= w_head_d;
        r_word_m <= w_head_m;
      end
      if (w_drop) r_overflow <= 1'b1;
      r_idx   <= w_nxt_idx;
      r_state <= w_nxt_state;
      r_valid <= w_out_valid;
      r_jpeg  <= w_out_byte;
    end
  end

  assign o_valid    = r_valid;
  assign o_jpeg     = r_jpeg;
  assign o_overflow = r_overflow;
  assign o_state    = r_state;

endmodule

// File: rtl/bitstream_stuff.sv
// Variable-length code packer: MSB-first data/mask accumulator that emits whole
// 32-bit words into the byte stuffer, plus byte-alignment (rest) tracking.
module bitstream_stuff
  import bitstream_stuff_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  bitstream_stuff_if.slave bus
);

  logic                r_rst_sync;
  logic                w_rst_n;
  logic [LEN_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_acc_d, r_acc_m;
  logic [2:0]          r_rest;
  logic                r_wr;
  logic [CODE_W-1:0]   r_wr_d, r_wr_m;

  logic [LEN_W-1:0]    w_len, w_total, w_nxt_cnt;
  logic [CODE_W-1:0]   w_len_mask;
  logic [2*CODE_W-1:0] w_cat_d, w_cat_m;
  logic                w_word_done;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 1'b0;
    else      r_rst_sync <= 1'b1;
  end
  assign w_rst_n = r_rst_sync;

  // Bits above count in the accumulator are stale; they always land above
  // w_total after the shift, so only the slice below w_total is ever used.
  always_comb begin
    w_len       = (bus.ilength > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : bus.ilength;
    w_len_mask  = {CODE_W{1'b1}} >> (LEN_W'(CODE_W) - w_len);
    w_cat_d     = ({{CODE_W{1'b0}}, r_acc_d} << w_len)
                | {{CODE_W{1'b0}}, bus.idata & w_len_mask};
    w_cat_m     = ({{CODE_W{1'b0}}, r_acc_m} << w_len)
                | {{CODE_W{1'b0}}, bus.inostuff & w_len_mask};
    w_total     = r_cnt + w_len;
    w_word_done = w_total[LEN_W-1];
    w_nxt_cnt   = {1'b0, w_total[LEN_W-2:0]};
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_acc_d <= '0;
      r_acc_m <= '0;
      r_cnt   <= '0;
      r_rest  <= '0;
      r_wr    <= 1'b0;
      r_wr_d  <= '0;
      r_wr_m  <= '0;
    end else begin
      r_acc_d <= w_cat_d[CODE_W-1:0];
      r_acc_m <= w_cat_m[CODE_W-1:0];
      r_cnt   <= w_nxt_cnt;
      r_rest  <= 3'd0 - w_nxt_cnt[2:0];
      r_wr    <= w_word_done;
      if (w_word_done) begin
        r_wr_d <= CODE_W'(w_cat_d >> w_total[LEN_W-2:0]);
        r_wr_m <= CODE_W'(w_cat_m >> w_total[LEN_W-2:0]);
      end
    end
  end

  assign bus.rest = r_rest;

  bitstream_stuff_byte_stuffer #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_byte_stuffer (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_wr       (r_wr),
    .i_wr_data  (r_wr_d),
    .i_wr_mask  (r_wr_m),
    .o_valid    (bus.valid),
    .o_jpeg     (bus.jpeg),
    .o_overflow (bus.overflow),
    .o_state    (bus.dbg_state)
  );

endmodule

// File: tb/tb_bitstream_stuff.sv
// Directed bench for bitstream_stuff: byte order, latency, stuffing, alignment
// and FIFO overflow.
`timescale 1ns/1ps
module tb_bitstream_stuff;
  import bitstream_stuff_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc = 0;

  logic [7:0] got_q[$];
  int         stamp_q[$];
  logic [7:0] exp_q[$];

  bitstream_stuff_if bus();

  bitstream_stuff #(.FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      got_q.push_back(bus.jpeg);
      stamp_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic send_code(input int len, input logic [31:0] d, input logic [31:0] m);
    @(negedge clk);
    bus.ilength  = len[5:0];
    bus.idata    = d;
    bus.inostuff = m;
    @(posedge clk);
    #1;
    last_acc     = cyc;
    bus.ilength  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    got_q.delete();
    stamp_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    n_checks++;
    if (bus.rest !== 3'd0) begin n_fail++; $display("FAIL reset_rest: got %0d expected 0", bus.rest); end
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_checks++;
    if (bus.jpeg !== 8'h00) begin n_fail++; $display("FAIL reset_jpeg: got %h expected 00", bus.jpeg); end
    @(negedge clk);
    rst = 1'b1;
    clear_queues();
    idle(10);
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_idle_bytes: got %0d expected 0", got_q.size()); end
  endtask

  task automatic test_byte_order();
    clear_queues();
    send_code(8, 32'h12, 32'h0);
    send_code(8, 32'h34, 32'h0);
    send_code(8, 32'h56, 32'h0);
    send_code(8, 32'h78, 32'h0);
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    idle(20);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL order_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL order_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++;
      if (stamp_q[0] != last_acc + 2) begin
        n_fail++; $display("FAIL order_latency: got cycle %0d expected %0d", stamp_q[0], last_acc + 2);
      end
      n_checks++;
      if (stamp_q[3] != stamp_q[0] + 3) begin
        n_fail++; $display("FAIL order_contiguous: got span %0d expected 3", stamp_q[3] - stamp_q[0]);
      end
    end
  endtask

  task automatic test_stuffing(input logic [31:0] m, input string name);
    clear_queues();
    send_code(32, 32'hFFAB00FF, m);
    if (m == 32'h0) exp_q = '{8'hFF, 8'h00, 8'hAB, 8'h00, 8'hFF, 8'h00};
    else            exp_q = '{8'hFF, 8'hAB, 8'h00, 8'hFF};
    idle(20);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_byte%0d: got %h expected %h", name, i, got_q[i], exp_q[i]); end
      end
      n_checks++;
      if (stamp_q[exp_q.size()-1] != stamp_q[0] + exp_q.size() - 1) begin
        n_fail++; $display("FAIL %s_contiguous: got span %0d expected %0d", name,
                           stamp_q[exp_q.size()-1] - stamp_q[0], exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_rest();
    clear_queues();
    send_code(3, 32'h5, 32'h0);
    n_checks++;
    if (bus.rest !== 3'd5) begin n_fail++; $display("FAIL rest_after_3: got %0d expected 5", bus.rest); end
    send_code(5, 32'h1F, 32'h0);
    n_checks++;
    if (bus.rest !== 3'd0) begin n_fail++; $display("FAIL rest_after_8: got %0d expected 0", bus.rest); end
    send_code(24, 32'h0, 32'h0);
    exp_q = '{8'hBF, 8'h00, 8'h00, 8'h00};
    idle(20);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rest_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rest_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_partial();
    clear_queues();
    send_code(20, 32'hFFFABCDE, 32'h0);
    n_checks++;
    if (bus.rest !== 3'd4) begin n_fail++; $display("FAIL partial_rest20: got %0d expected 4", bus.rest); end
    send_code(20, 32'h00012345, 32'h0);
    n_checks++;
    if (bus.rest !== 3'd0) begin n_fail++; $display("FAIL partial_rest40: got %0d expected 0", bus.rest); end
    exp_q = '{8'hAB, 8'hCD, 8'hE1, 8'h23};
    idle(20);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL partial_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL partial_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  // Reading one word per 4 cycles against one write per cycle: the FIFO fills
  // after word 10; from then only words written on a pop edge (13,17,..,37) fit.
  task automatic test_overflow();
    logic [31:0] w;
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    clear_queues();
    for (int k = 0; k < 40; k++) begin
      send_code(32, 32'h10203040 + k, 32'h0);
      if (k == 11) begin
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before_full: got %b expected 0", bus.overflow); end
      end
      if (k == 12) begin
        n_checks++;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_on_drop: got %b expected 1", bus.overflow); end
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (k <= 10 || (k >= 13 && ((k - 13) % 4) == 0)) begin
        w = 32'h10203040 + k;
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
    end
    idle(100);
    n_checks++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++;
      if (stamp_q[exp_q.size()-1] != stamp_q[0] + exp_q.size() - 1) begin
        n_fail++; $display("FAIL ovf_contiguous: got span %0d expected %0d",
                           stamp_q[exp_q.size()-1] - stamp_q[0], exp_q.size() - 1);
      end
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b expected 0", bus.overflow); end
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_valid: got %b expected 0", bus.valid); end
    idle(2);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.ilength  = '0;
    bus.idata    = '0;
    bus.inostuff = '0;
    test_reset();
    test_byte_order();
    test_stuffing(32'h0, "stuff");
    test_stuffing(32'hFFFFFFFF, "marker");
    test_rest();
    test_partial();
    test_overflow();
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
